// File: rtl/proj_one_pkg.sv
// -----------------------------------------------------------------------------
// proj_one_pkg
//   Shared definitions for the proj_one population-count stage.
//   - DEFAULT_WIDTH : default number of input bits counted.
//   - cnt_width(w)  : bits needed to hold a count of 0..w ones.
// -----------------------------------------------------------------------------
package proj_one_pkg;

   localparam int DEFAULT_WIDTH = 7;

   // A count of w ones ranges over 0..w, so it needs clog2(w+1) bits.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage : proj_one_pkg

// File: rtl/proj_one_popcount_tree.sv
// -----------------------------------------------------------------------------
// popcount_tree
//   Purely combinational pairwise adder tree that counts the 1 bits of a word.
//   The word is split into a low and a high half, each half is counted by a
//   smaller copy of this module, and the two partial counts are added. Each
//   partial sum is cnt_width(its own width) bits wide, which always holds its
//   own maximum, so no level can overflow.
//
//   Parameters:
//     WIDTH : number of input bits (1..64)
//   Ports:
//     bits  : input  [WIDTH-1:0]  word to count
//     sum   : output [CW-1:0]     number of 1 bits in bits
// -----------------------------------------------------------------------------
module popcount_tree
   import proj_one_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CW    = cnt_width(WIDTH)
) (
   input  logic [WIDTH-1:0] bits,
   output logic [CW-1:0]    sum
);

   if (WIDTH == 1) begin : g_leaf
      // A single bit is its own count.
      assign sum = bits;
   end else begin : g_split
      localparam int LW  = WIDTH / 2;
      localparam int HW  = WIDTH - LW;
      localparam int LCW = cnt_width(LW);
      localparam int HCW = cnt_width(HW);

      logic [LCW-1:0] lo_sum;
      logic [HCW-1:0] hi_sum;

      popcount_tree #(.WIDTH(LW)) u_lo (
         .bits (bits[LW-1:0]),
         .sum  (lo_sum)
      );

      popcount_tree #(.WIDTH(HW)) u_hi (
         .bits (bits[WIDTH-1:LW]),
         .sum  (hi_sum)
      );

      // Both halves are zero-extended to the parent width before the add; the
      // parent width holds WIDTH, which bounds lo_sum + hi_sum.
      assign sum = CW'(lo_sum) + CW'(hi_sum);
   end

endmodule : popcount_tree

// File: rtl/proj_one.sv
// -----------------------------------------------------------------------------
// proj_one
//   Registered population counter. The 1 bits of i0 are counted by a
//   combinational adder tree and the count plus three status flags are
//   registered, giving exactly one cycle of latency and one result per cycle.
//
//   Parameters:
//     WIDTH  : number of input bits counted (1..64)
//     CW     : count width, derived as cnt_width(WIDTH)
//   Ports:
//     clk    : input          rising-edge clock
//     reset  : input          synchronous, active-high reset
//     i0     : input  [WIDTH] data word sampled every rising edge
//     o      : output [CW]    registered count of 1 bits in i0
//     o_zero : output         registered, count == 0
//     o_all  : output         registered, count == WIDTH
//     o_odd  : output         registered, LSB of count (odd parity of i0)
// -----------------------------------------------------------------------------
module proj_one
   import proj_one_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CW    = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i0,
   output logic [CW-1:0]    o,
   output logic             o_zero,
   output logic             o_all,
   output logic             o_odd
);

   logic [CW-1:0] count;

   popcount_tree #(.WIDTH(WIDTH)) u_tree (
      .bits (i0),
      .sum  (count)
   );

   // Flags are decoded from the unregistered count and registered alongside
   // it, so every output comes straight from a flop and all four describe the
   // same sampled word.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values and the result does not depend on statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         o      <= '0;
         o_zero <= 1'b1;
         o_all  <= 1'b0;
         o_odd  <= 1'b0;
      end else begin
         o      <= count;
         o_zero <= (count == '0);
         o_all  <= (count == CW'(WIDTH));
         o_odd  <= count[0];
      end
   end

endmodule : proj_one

// File: tb/tb_proj_one.sv
// -----------------------------------------------------------------------------
// tb_proj_one
//   Self-checking bench for proj_one at WIDTH=7 (default), WIDTH=1 and
//   WIDTH=16. Expected results are pushed to a per-DUT queue when stimulus is
//   driven and popped one edge later when the registered result is sampled.
// -----------------------------------------------------------------------------
module tb_proj_one;

   // Expected/observed result: count zero-extended to 8 bits plus the flags.
   typedef struct packed {
      logic [7:0] cnt;
      logic       zero;
      logic       all;
      logic       odd;
   } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;

   logic [6:0]  i7;
   logic [2:0]  o7;
   logic        z7, a7, p7;

   logic [0:0]  i1;
   logic [0:0]  o1;
   logic        z1, a1, p1;

   logic [15:0] i16;
   logic [4:0]  o16;
   logic        z16, a16, p16;

   res_t q7[$];
   res_t q1[$];
   res_t q16[$];

   int checks   = 0;
   int failures = 0;

   proj_one dut (
      .clk    (clk),
      .reset  (reset),
      .i0     (i7),
      .o      (o7),
      .o_zero (z7),
      .o_all  (a7),
      .o_odd  (p7)
   );

   proj_one #(.WIDTH(1)) dut_w1 (
      .clk    (clk),
      .reset  (reset),
      .i0     (i1),
      .o      (o1),
      .o_zero (z1),
      .o_all  (a1),
      .o_odd  (p1)
   );

   proj_one #(.WIDTH(16)) dut_w16 (
      .clk    (clk),
      .reset  (reset),
      .i0     (i16),
      .o      (o16),
      .o_zero (z16),
      .o_all  (a16),
      .o_odd  (p16)
   );

   // Reference model: bit-serial count, independent of the tree structure.
   function automatic res_t model(input logic [63:0] w, input int width);
      res_t r;
      int   n = 0;
      for (int i = 0; i < width; i++) n += int'(w[i]);
      r.cnt  = 8'(n);
      r.zero = (n == 0);
      r.all  = (n == width);
      r.odd  = n[0];
      return r;
   endfunction

   function automatic res_t mk(input int cnt, input logic zero, input logic all,
                               input logic odd);
      res_t r;
      r.cnt  = 8'(cnt);
      r.zero = zero;
      r.all  = all;
      r.odd  = odd;
      return r;
   endfunction

   // Stimulus helpers: drive inputs and push what must appear one edge later.
   task automatic drive7(input logic [6:0] v, input logic rst, input res_t e);
      i7    = v;
      reset = rst;
      q7.push_back(e);
   endtask

   task automatic drive1(input logic [0:0] v);
      i1    = v;
      reset = 1'b0;
      q1.push_back(model(64'(v), 1));
   endtask

   task automatic drive16(input logic [15:0] v);
      i16   = v;
      reset = 1'b0;
      q16.push_back(model(64'(v), 16));
   endtask

   function automatic res_t got7();
      return {8'(o7), z7, a7, p7};
   endfunction

   // Watchdog: the bench is clock-driven only, but never let it run away.
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got timeout required finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      res_t e, g;
      // Two reset edges with all ones on the input.
      for (int k = 0; k < 2; k++) begin
         drive7(7'b1111111, 1'b1, mk(0, 1'b1, 1'b0, 1'b0));
         @(posedge clk); #1;
         e = q7.pop_front(); g = got7(); checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL reset_hold[%0d]: got %p required %p", k, g, e);
         end
      end
      // First edge after release reflects the all-ones word.
      drive7(7'b1111111, 1'b0, mk(7, 1'b0, 1'b1, 1'b1));
      @(posedge clk); #1;
      e = q7.pop_front(); g = got7(); checks++;
      if (g !== e) begin
         failures++;
         $display("FAIL reset_release: got %p required %p", g, e);
      end
   endtask

   task automatic test_basic();
      logic [6:0] v [3];
      res_t       ex[3];
      res_t       e, g;
      v[0] = 7'b0000000; ex[0] = mk(0, 1'b1, 1'b0, 1'b0);
      v[1] = 7'b0000011; ex[1] = mk(2, 1'b0, 1'b0, 1'b0);
      v[2] = 7'b0000010; ex[2] = mk(1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         drive7(v[k], 1'b0, ex[k]);
         @(posedge clk); #1;
         e = q7.pop_front(); g = got7(); checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL basic[%0d] i0=%b: got %p required %p", k, v[k], g, e);
         end
      end
   endtask

   task automatic test_mixed();
      logic [6:0] v [2];
      res_t       ex[2];
      res_t       e, g;
      v[0] = 7'b1010100; ex[0] = mk(3, 1'b0, 1'b0, 1'b1);
      v[1] = 7'b1111010; ex[1] = mk(5, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
         drive7(v[k], 1'b0, ex[k]);
         @(posedge clk); #1;
         e = q7.pop_front(); g = got7(); checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL mixed[%0d] i0=%b: got %p required %p", k, v[k], g, e);
         end
      end
   endtask

   task automatic test_walk();
      res_t e, g;
      logic [6:0] v;
      for (int b = 0; b < 7; b++) begin
         v = 7'(1 << b);
         drive7(v, 1'b0, mk(1, 1'b0, 1'b0, 1'b1));
         @(posedge clk); #1;
         e = q7.pop_front(); g = got7(); checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL walk bit%0d: got %p required %p", b, g, e);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [6:0] v [3];
      logic       r [3];
      res_t       ex[3];
      res_t       e, g;
      // The reset edge discards 1111010; the next edge reflects 0000010.
      v[0] = 7'b1111010; r[0] = 1'b0; ex[0] = mk(5, 1'b0, 1'b0, 1'b1);
      v[1] = 7'b1111010; r[1] = 1'b1; ex[1] = mk(0, 1'b1, 1'b0, 1'b0);
      v[2] = 7'b0000010; r[2] = 1'b0; ex[2] = mk(1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         drive7(v[k], r[k], ex[k]);
         @(posedge clk); #1;
         e = q7.pop_front(); g = got7(); checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL mid_reset[%0d]: got %p required %p", k, g, e);
         end
      end
   endtask

   task automatic test_back_to_back_sweep();
      res_t e, g;
      for (int n = 0; n < 128; n++) begin
         drive7(7'(n), 1'b0, model(64'(n), 7));
         @(posedge clk); #1;
         e = q7.pop_front(); g = got7(); checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL sweep i0=%0d: got %p required %p", n, g, e);
         end
      end
   endtask

   task automatic test_width1();
      logic [0:0] v;
      res_t       e, g;
      for (int n = 0; n < 6; n++) begin
         v = 1'(n >> 1);
         drive1(v);
         @(posedge clk); #1;
         e = q1.pop_front(); g = {8'(o1), z1, a1, p1}; checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL width1 i0=%b: got %p required %p", v, g, e);
         end
      end
   endtask

   task automatic test_width16();
      logic [15:0] v;
      res_t        e, g;
      for (int n = 0; n < 250; n++) begin
         if (n == 0)       v = 16'h0000;
         else if (n == 1)  v = 16'hffff;
         else if (n < 18)  v = 16'(1 << (n - 2));
         else if (n == 18) v = 16'h7fff;
         else              v = 16'($urandom);
         drive16(v);
         @(posedge clk); #1;
         e = q16.pop_front(); g = {8'(o16), z16, a16, p16}; checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL width16 i0=%h: got %p required %p", v, g, e);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      i7    = '0;
      i1    = '0;
      i16   = '0;
      test_reset();
      test_basic();
      test_mixed();
      test_walk();
      test_mid_reset();
      test_back_to_back_sweep();
      test_width1();
      test_width16();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_proj_one

// File: doc/proj_one.md
Name: proj_one

Overview:
- Registered population counter: counts the 1 bits in a WIDTH-bit input word and presents the count one clock later.
- Default configuration is 7-bit input, 3-bit count.
- Standalone datapath leaf used as a bit-count stage in the project top level.
- Also provides zero, all-ones and odd-parity status flags derived from the same registered count.

Parameters:
- WIDTH, 7, number of input bits counted; legal range 1..64.
- CW, $clog2(WIDTH+1), count width. It is derived, not overridden; equals 3 for WIDTH=7.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- i0  input  WIDTH  data word whose 1 bits are counted; sampled every rising edge.
- o  output  CW  registered count of 1 bits in i0.
- o_zero  output  1  registered; 1 when the registered count is 0.
- o_all  output  1  registered; 1 when the registered count equals WIDTH.
- o_odd  output  1  registered; equals the LSB of the count (odd parity of the sampled word).

Behaviour:
- Single clock, clk. Reset is synchronous and active-high, named reset.
- Reset:
  - When reset=1 at a rising edge: o=0, o_zero=1, o_all=0, o_odd=0.
  - Reset has priority over the data path.
  - Asserting reset mid-stream discards the in-flight sample.
- Latency: exactly 1 cycle, no handshake.
  - At each rising edge with reset=0, o <= popcount(i0 as sampled at that edge).
  - Flags update on the same edge from the same sampled word.
- Outputs hold their value between edges and do not glitch. All outputs come straight from flops.
- Arithmetic:
  - The count is computed combinationally by an unsigned adder tree over the WIDTH bits.
  - Every partial sum is sized to hold its own maximum, so no intermediate overflow occurs.
  - The final sum is exactly CW bits; the maximum value is WIDTH and always fits.
- Boundaries:
  - i0 all zeros gives o=0 and o_zero=1.
  - i0 all ones gives o=WIDTH (7) and o_all=1.
  - Each single-bit input gives o=1 regardless of bit position.
- X/Z on i0 is not specified. The implementation needs no special handling.
- No internal state beyond the output registers; no FSM.
- Back-to-back changes on every cycle are fully supported, with one result per cycle.

Decomposition:
- Shared package, proj_one_pkg:
  - function cnt_width(w) returning $clog2(w+1);
  - localparam DEFAULT_WIDTH=7.
- One natural sub-module: popcount_tree.
  - Purely combinational, parameterised by WIDTH.
  - Recursive or generate-based pairwise adder tree: input WIDTH bits, output CW-bit sum.
- proj_one instantiates popcount_tree and adds the output/flag register stage plus reset.

Test Plan:
1. Reset held for the first 2 edges with i0=7'b1111111 -> o=0, o_zero=1, o_all=0, o_odd=0 throughout reset; first edge after release -> o=7, o_all=1, o_odd=1.
2. Apply 7'b0000000, 7'b0000011, 7'b0000010 on successive cycles -> o=0, 2, 1 one edge after each; o_zero=1 only for the first; o_odd=0, 0, 1.
3. Apply 7'b1010100 then 7'b1111010 -> o=3 then 5; o_odd=1 for both; o_all=0.
4. Walking single 1 through bit 0..6 -> o=1 every cycle; o_zero=0, o_all=0.
5. Assert reset for one cycle between i0=7'b1111010 and the next sample -> o=0 on the reset edge; next edge reflects the then-current i0 (e.g. 7'b0000010 -> 1).
6. Exhaustive sweep of all 128 input values, one per cycle, each compared against a reference model one cycle later -> zero mismatches; also rerun with WIDTH=1 and WIDTH=16 (o max 1 and 16, CW=1 and 5).
